// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: turns 1/2/4-byte IF/LS requests into
// single-byte bus transactions and assembles little-endian results.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        flush,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic        r_owner_ls;
    logic [31:0] r_base;
    logic [2:0]  r_n;
    logic [31:0] r_wdata;
    logic [31:0] r_result;
    logic [2:0]  r_issue;
    logic [2:0]  r_cap;
    logic        r_pend;
    logic [2:0]  w_ls_n;
    logic [31:0] w_addr;

    assign w_ls_n = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
    assign w_addr = r_base + {29'd0, r_issue};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_owner_ls <= 1'b0;
            r_base     <= '0;
            r_n        <= '0;
            r_wdata    <= '0;
            r_result   <= '0;
            r_issue    <= '0;
            r_cap      <= '0;
            r_pend     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (rdy_in) begin
                    r_issue <= '0;
                    r_cap   <= '0;
                    r_pend  <= 1'b0;
                    if (ls_req) begin
                        r_owner_ls <= 1'b1;
                        r_base     <= ls_addr;
                        r_n        <= w_ls_n;
                        r_wdata    <= ls_wdata;
                        r_result   <= '0;
                        r_state    <= ls_wr ? S_WRITE : S_READ;
                    end else if (if_req && !flush) begin
                        r_owner_ls <= 1'b0;
                        r_base     <= if_addr;
                        r_n        <= 3'd4;
                        r_result   <= '0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (flush && !r_owner_ls) begin
                        r_state <= S_IDLE;
                    end else if (rdy_in) begin
                        // r_pend: a byte was issued last cycle with the bus ours
                        if (r_pend) begin
                            r_result[{r_cap[1:0], 3'b000} +: 8] <= mem_din;
                            r_cap <= r_cap + 3'd1;
                        end
                        if (r_issue < r_n) begin
                            r_pend  <= 1'b1;
                            r_issue <= r_issue + 3'd1;
                        end else begin
                            r_pend  <= 1'b0;
                        end
                        if (r_pend && (r_cap == r_n - 3'd1))
                            r_state <= S_DONE;
                    end else begin
                        // lost the in-flight byte; re-issue it on resume
                        r_issue <= r_cap;
                        r_pend  <= 1'b0;
                    end
                end
                S_WRITE: if (rdy_in) begin
                    if (r_issue == r_n - 3'd1)
                        r_state <= S_DONE;
                    else
                        r_issue <= r_issue + 3'd1;
                end
                default: if (rdy_in) r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (r_state == S_READ) begin
            mem_a = w_addr;
        end else if (r_state == S_WRITE) begin
            mem_a    = w_addr;
            mem_dout = r_wdata[{r_issue[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in;
        end
    end

    assign if_ack   = (r_state == S_DONE) && rdy_in && !r_owner_ls && !flush;
    assign ls_ack   = (r_state == S_DONE) && rdy_in && r_owner_ls;
    assign if_data  = r_result;
    assign ls_rdata = r_result;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, vector table, ack scoreboard and
// hand-written stall / flush / reset sequences.
module tb_mem_ctrl;
    logic        clk_in, rst_n_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_ack, flush;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_ack;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .flush(flush), .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    typedef struct {
        bit          is_if;
        bit          rd;
        logic [31:0] data;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in && (if_ack || ls_ack)) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_ack if_ack=%0b ls_ack=%0b", if_ack, ls_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_owner", {31'd0, if_ack}, {31'd0, e.is_if});
                chk("ack_latency", cyc - e.t0, e.lat);
                if (e.rd) chk("ack_data", e.is_if ? if_data : ls_rdata, e.data);
            end
        end
    end

    task automatic push_exp(input bit is_if, input bit rd, input logic [31:0] d, input int lat);
        exp_t e;
        e.is_if = is_if; e.rd = rd; e.data = d; e.t0 = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic timeout(input string name);
        checks++; fails++;
        $display("FAIL %s timeout waiting for ack", name);
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  n, wrcnt;
        bit  got;
        n = v.is_if ? 4 : (v.size == 2'd0 ? 1 : (v.size == 2'd1 ? 2 : 4));
        @(negedge clk_in);
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            ls_req = 1'b1; ls_wr = v.wr; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
        end
        push_exp(v.is_if, !v.wr, v.exp_data, v.lat);
        wrcnt = 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_in);
            if (mem_wr) wrcnt++;
            if (k <= n) begin
                chk("beat_addr", mem_a, v.addr + 32'(k - 1));
                chk("beat_wr", {31'd0, mem_wr}, {31'd0, v.wr});
                if (v.wr) chk("beat_dout", {24'd0, mem_dout}, (v.wdata >> (8 * (k - 1))) & 32'hff);
            end
            if (if_ack || ls_ack) begin
                got = 1'b1; if_req = 1'b0; ls_req = 1'b0;
            end
        end
        if (!got) timeout("vector");
        chk("wr_cycles", wrcnt, v.wr ? n : 0);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0200] = 8'h93; ram[16'h0202] = 8'h10;

        //          is_if wr size addr          wdata         exp_data      lat
        vt[0]  = '{1'b0, 1'b1, 2'd0, 32'h0000_3000, 32'h0000_00A5, 32'h0,         2};
        vt[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_3000, 32'h0,         32'h0000_00A5, 3};
        vt[2]  = '{1'b0, 1'b1, 2'd1, 32'h0000_1002, 32'h0000_BEEF, 32'h0,         3};
        vt[3]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'hBEEF_0000, 6};
        vt[4]  = '{1'b0, 1'b0, 2'd1, 32'h0000_1003, 32'h0,         32'h0000_00BE, 4};
        vt[5]  = '{1'b0, 1'b1, 2'd2, 32'h0003_0010, 32'h1122_3344, 32'h0,         5};
        vt[6]  = '{1'b0, 1'b0, 2'd2, 32'h0003_0010, 32'h0,         32'h1122_3344, 6};
        vt[7]  = '{1'b0, 1'b0, 2'd3, 32'h0003_0012, 32'h0,         32'h0000_1122, 6};
        vt[8]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         5};
        vt[9]  = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 6};
        vt[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_0513, 6};

        rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0;
        ls_size = '0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("rst_acks", {30'd0, if_ack, ls_ack}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_n_in = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);
        chk("ram_1002", {24'd0, ram[16'h1002]}, 32'hEF);
        chk("ram_1003", {24'd0, ram[16'h1003]}, 32'hBE);

        // Simultaneous requests: LS wins, fetch follows in the IDLE after DONE
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h3000;
        push_exp(1'b0, 1'b1, 32'h0000_00A5, 3);
        push_exp(1'b1, 1'b1, 32'h0000_0513, 10);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_in);
            if (k == 5) chk("simul_fetch_issue", mem_a, 32'h100);
            if (ls_ack) ls_req = 1'b0;
            if (if_ack) begin got = 1'b1; if_req = 1'b0; end
        end
        if (!got) timeout("simul");

        // Load stalled for 3 cycles right after its second byte is issued
        @(negedge clk_in);
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h1000;
        push_exp(1'b0, 1'b1, 32'hBEEF_0000, 10);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_in);
            if (k == 3) rdy_in = 1'b0;
            if (k == 6) begin
                rdy_in = 1'b1;
                chk("stall_reissue_addr", mem_a, 32'h1001);
            end
            if (k >= 3 && k <= 5) begin
                #1 chk("stall_rd_wr", {31'd0, mem_wr}, 32'h0);
            end
            if (ls_ack) begin got = 1'b1; ls_req = 1'b0; end
        end
        if (!got) timeout("stall_load");

        // Store with the bus taken away during its first byte
        @(negedge clk_in);
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h3100; ls_wdata = 32'h1234;
        push_exp(1'b0, 1'b0, 32'h0, 4);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                rdy_in = 1'b0;
                #1 chk("stall_wr_forced", {31'd0, mem_wr}, 32'h0);
            end
            if (k == 2) rdy_in = 1'b1;
            if (ls_ack) begin got = 1'b1; ls_req = 1'b0; end
        end
        if (!got) timeout("stall_store");
        chk("ram_3100", {24'd0, ram[16'h3100]}, 32'h34);
        chk("ram_3101", {24'd0, ram[16'h3101]}, 32'h12);

        // Flush in the third issue slot, then a new fetch on the very next cycle
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h100;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk_in);
            if (k == 3) begin flush = 1'b1; if_req = 1'b0; end
            if (k == 4) begin
                flush = 1'b0; if_req = 1'b1; if_addr = 32'h200;
                push_exp(1'b1, 1'b1, 32'h0010_0093, 6);
            end
            if (if_ack) begin got = 1'b1; if_req = 1'b0; end
        end
        if (!got) timeout("flush");

        // Reset in the middle of a word store
        for (int i = 0; i < 4; i++) ram[16'h2000 + i] = 8'h00;
        @(negedge clk_in);
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h2000; ls_wdata = 32'h5566_7788;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_mem_a", mem_a, 32'h0);
        chk("midrst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("midrst_mem_dout", {24'd0, mem_dout}, 32'h0);
        chk("midrst_acks", {30'd0, if_ack, ls_ack}, 32'h0);
        ls_req = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        chk("midrst_ram", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'h0000_7788);
        begin
            vec_t v;
            v = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0, 32'h0000_7788, 6};
            run_vec(v);
        end

        repeat (3) @(negedge clk_in);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller inside `cpu` that drives the byte-wide `mem_a` / `mem_wr` / `mem_dout` / `mem_din` port of the top level. It serves two internal requesters: instruction fetch (IF) and load/store (LS). It serialises 1/2/4-byte accesses into single-byte RAM/IO transactions and assembles little-endian results. It honours `rdy_in`, which is low while the host debug interface owns the bus.

## Interface
- No parameters.
- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `rdy_in`  in  1  bus-ready; low = bus owned by the host debug interface, block stalls.
- `mem_din`  in  8  read byte; valid the cycle after its address was presented.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write, 0 = read.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  32  fetch address; always a 4-byte access.
- `if_ack`  out  1  one-cycle pulse; `if_data` valid in the same cycle.
- `if_data`  out  32  fetched word.
- `flush`  in  1  abort any pending or in-progress fetch.
- `ls_req`  in  1  load/store request; held with `ls_*` until `ls_ack`.
- `ls_wr`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `ls_addr`  in  32  data address.
- `ls_wdata`  in  32  store data; low N bytes used.
- `ls_ack`  out  1  one-cycle pulse; `ls_rdata` valid in the same cycle.
- `ls_rdata`  out  32  load data, zero-extended; sign extension is done by the LSU.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE:** samples requests each `rdy_in`-high cycle.
  - `ls_req` has priority over `if_req`.
  - `flush` high blocks acceptance of `if_req` in that cycle.
  - On acceptance, latch base address, N (1/2/4), direction and write data, and record the owner (IF or LS). Go to READ or WRITE.
- **READ:** N issue slots followed by one capture slot.
  - Slot k (k < N) drives `mem_a` = base + k and `mem_wr` = 0.
  - The byte arriving on `mem_din` the following cycle is stored into result bits [8k+7:8k].
  - After byte N-1 is captured, go to DONE.
- **WRITE:** N cycles, each driving `mem_a` = base + k, `mem_dout` = wdata[8k+7:8k], `mem_wr` = 1. Then go to DONE.
- **DONE:** pulse the owner's ack for one cycle (result on `if_data` or `ls_rdata`), then return to IDLE. Requests are not sampled in DONE, so the requester must drop or replace its request by the cycle after ack.
- **Address arithmetic:** base + k is computed modulo 2^32; wrap-around is permitted. No alignment checking; misaligned accesses are serialised normally.
- **IO space** (address bits [17:16] = 2'b11) is handled identically to RAM, one byte per access.
- **Flush:**
  - While the owner is IF in READ, `flush` returns the FSM to IDLE on the next edge with no ack.
  - `flush` in a DONE cycle owned by IF suppresses `if_ack`.
  - `flush` never affects an LS access.
- **rdy_in low:**
  - State, counters and result registers hold.
  - `mem_wr` is forced to 0.
  - A read byte is captured only if both its issue cycle and the following cycle had `rdy_in` high. Otherwise the byte is re-issued on resume (the issue index rewinds to the capture index).
  - A write byte counts only if `rdy_in` was high in its cycle.

## Timing
- **Reset values:** `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0, `if_ack` = 0, `ls_ack` = 0, `if_data` = 0, `ls_rdata` = 0, state = IDLE.
- **Reset mid-operation:** takes effect immediately. A partially written store remains partially written; this is accepted.
- **Read latency** (request sampled in IDLE at cycle T, no stall): issue in T+1 … T+N, capture in T+2 … T+N+1, ack in T+N+2. A word fetch therefore acks at T+6.
- **Write latency:** `mem_wr` is high in T+1 … T+N, ack in T+N+1.
- **Stalls:** each `rdy_in`-low cycle adds at least one cycle to latency. An interrupted read byte adds one more cycle for its re-issue.
- **Back-to-back:** the earliest new acceptance is the IDLE cycle following DONE. The losing requester is accepted then if still asserting.

## Test plan
- **Word fetch:** RAM[0x100..0x103] = 13 05 00 00; `if_req` with `if_addr` = 0x100 at T -> `mem_a` = 0x100..0x103 in T+1..T+4, `if_ack` at T+6, `if_data` = 0x00000513.
- **Half store then word load:**
  - Store half 0xBEEF to 0x1002 -> `mem_wr` high exactly 2 cycles, RAM[0x1002] = EF and RAM[0x1003] = BE, `ls_ack` at T+3.
  - Word load from 0x1000 (RAM[0x1000..0x1001] = 0) -> `ls_rdata` = 0xBEEF0000.
- **Simultaneous requests:** `if_req` and `ls_req` (byte load) both asserted at T -> `ls_ack` at T+3, fetch issues from T+5, `if_ack` at T+10.
- **Stall during load:** `rdy_in` low for 3 cycles after the second byte of a word load is issued -> `mem_wr` stays 0, the second byte is re-issued, `ls_rdata` is correct, ack at T+10.
- **Flush mid-fetch:** `flush` during a fetch's third issue slot -> no `if_ack`, IDLE next cycle; a following fetch from 0x200 returns correct data.
- **Reset mid-store:** `rst_n_in` low after 2 bytes of a word store to 0x2000 -> all outputs take reset values immediately, only RAM[0x2000..0x2001] changed, FSM in IDLE after release.
